// File: rtl/fft8_stream.sv
// fft8_stream: forward 8-point radix-2 DIT FFT with a single time-shared butterfly.
// Samples arrive serially and are stored bit-reversed; 3 stages x 4 butterflies
// run in place, each stage halving the result, so the 8 bins leave scaled by 1/8.
// Optional build macro FFT8_ROUND_EN: round-half-up on every >>>1 and >>>8
// instead of floor truncation. Timing and interface are the same either way.
module fft8_stream #(
    parameter int DW = 12,
    parameter int TW = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] xr,
    input  logic signed [DW-1:0] xi,
    output logic                 out_valid,
    output logic [2:0]           out_idx,
    output logic signed [DW-1:0] yr,
    output logic signed [DW-1:0] yi,
    output logic                 busy
);

    // Twiddles carry one bit more than TW so that +1.0 (256) is representable.
    localparam int PW = DW + TW + 2;
    localparam int AW = DW + 2;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic signed [DW-1:0] mem_re [0:7];
    logic signed [DW-1:0] mem_im [0:7];

    logic                 accept;
    logic [1:0]           stg;
    logic [1:0]           bfl;
    logic [2:0]           top;
    logic [2:0]           bot;
    logic [1:0]           tw_idx;
    logic signed [TW:0]   w_re;
    logic signed [TW:0]   w_im;
    logic signed [PW-1:0] p_re;
    logic signed [PW-1:0] p_im;
    logic signed [AW-1:0] t_re;
    logic signed [AW-1:0] t_im;
    logic signed [DW-1:0] a_re_n;
    logic signed [DW-1:0] a_im_n;
    logic signed [DW-1:0] b_re_n;
    logic signed [DW-1:0] b_im_n;

    function automatic logic [2:0] bitrev3(input logic [2:0] a);
        return {a[0], a[1], a[2]};
    endfunction

    function automatic logic signed [TW:0] tw_re(input logic [1:0] k);
        case (k)
            2'd0:    return (TW+1)'(256);
            2'd1:    return (TW+1)'(181);
            2'd2:    return '0;
            default: return -(TW+1)'(181);
        endcase
    endfunction

    function automatic logic signed [TW:0] tw_im(input logic [1:0] k);
        case (k)
            2'd0:    return '0;
            2'd1:    return -(TW+1)'(181);
            2'd2:    return -(TW+1)'(256);
            default: return -(TW+1)'(181);
        endcase
    endfunction

    // Drop the 8 fractional twiddle bits of a full-width product sum.
    function automatic logic signed [AW-1:0] shr8(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] r;
`ifdef FFT8_ROUND_EN
        r = v + PW'(128);
`else
        r = v;
`endif
        return AW'(r >>> 8);
    endfunction

    // Per-stage halving that keeps the overall gain at 1/8.
    function automatic logic signed [AW-1:0] half(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] r;
`ifdef FFT8_ROUND_EN
        r = v + AW'(1);
`else
        r = v;
`endif
        return r >>> 1;
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] v);
        if ((v[AW-1:DW-1] == '0) || (v[AW-1:DW-1] == '1))
            return $signed(v[DW-1:0]);
        else if (v[AW-1])
            return $signed({1'b1, {(DW-1){1'b0}}});
        else
            return $signed({1'b0, {(DW-1){1'b1}}});
    endfunction

    assign in_ready = ~rst & ((state == S_IDLE) || (state == S_LOAD));
    assign busy     = (state == S_CALC) || (state == S_OUT);
    assign accept   = in_valid & in_ready;
    assign stg      = cnt[3:2];
    assign bfl      = cnt[1:0];

    // Butterfly operand addresses and twiddle index for the current step.
    always_comb begin
        top    = {1'b0, bfl};
        bot    = {1'b1, bfl};
        tw_idx = bfl;
        case (stg)
            2'd0: begin
                top    = {bfl, 1'b0};
                bot    = {bfl, 1'b1};
                tw_idx = 2'd0;
            end
            2'd1: begin
                top    = {bfl[1], 1'b0, bfl[0]};
                bot    = {bfl[1], 1'b1, bfl[0]};
                tw_idx = {bfl[0], 1'b0};
            end
            default: ;
        endcase
    end

    // Butterfly datapath: complex twiddle multiply, sum/difference, halve, saturate.
    always_comb begin
        w_re   = tw_re(tw_idx);
        w_im   = tw_im(tw_idx);
        p_re   = PW'(w_re) * PW'(mem_re[bot]) - PW'(w_im) * PW'(mem_im[bot]);
        p_im   = PW'(w_re) * PW'(mem_im[bot]) + PW'(w_im) * PW'(mem_re[bot]);
        t_re   = shr8(p_re);
        t_im   = shr8(p_im);
        a_re_n = sat(half(AW'(mem_re[top]) + t_re));
        a_im_n = sat(half(AW'(mem_im[top]) + t_im));
        b_re_n = sat(half(AW'(mem_re[top]) - t_re));
        b_im_n = sat(half(AW'(mem_im[top]) - t_im));
    end

    // Sample RAM: bit-reversed loading, then in-place butterfly write-back.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_re[bitrev3(cnt[2:0])] <= xr;
            mem_im[bitrev3(cnt[2:0])] <= xi;
        end else if (state == S_CALC) begin
            mem_re[top] <= a_re_n;
            mem_im[top] <= a_im_n;
            mem_re[bot] <= b_re_n;
            mem_im[bot] <= b_im_n;
        end
    end

    // Frame sequencing FSM with registered output bins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            yr        <= '0;
            yi        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt   <= 4'd1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (cnt == 4'd7) begin
                            cnt   <= '0;
                            state <= S_CALC;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt == 4'd11) begin
                        // bin 0 was finished by the first stage-2 butterfly
                        cnt       <= '0;
                        state     <= S_OUT;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        yr        <= mem_re[0];
                        yi        <= mem_im[0];
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_OUT: begin
                    if (out_idx == 3'd7) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        out_idx <= out_idx + 3'd1;
                        yr      <= mem_re[out_idx + 3'd1];
                        yi      <= mem_im[out_idx + 3'd1];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft8_stream.sv
// Scoreboard bench for fft8_stream: a driver pushes expected bins when a frame
// completes loading; a negedge monitor pops and compares every presented bin.
module tb_fft8_stream;

    localparam int DW = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] xr;
    logic signed [DW-1:0] xi;
    logic                 out_valid;
    logic [2:0]           out_idx;
    logic signed [DW-1:0] yr;
    logic signed [DW-1:0] yi;
    logic                 busy;

    fft8_stream #(.DW(DW), .TW(9)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .xr(xr), .xi(xi), .out_valid(out_valid), .out_idx(out_idx),
        .yr(yr), .yi(yi), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int idx;
        int re;
        int im;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    int f_re[8];
    int f_im[8];
    int e_re[8];
    int e_im[8];
    int e0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", int'(out_valid), 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("bin%0d_idx", e.idx), int'(out_idx), e.idx);
                chk($sformatf("bin%0d_re", e.idx), int'(yr), e.re);
                chk($sformatf("bin%0d_im", e.idx), int'(yi), e.im);
                chk($sformatf("bin%0d_cycle", e.idx), cyc, e.cyc);
            end
        end
    end

    // Sends f_re/f_im; returns positioned 1 time unit after the edge that took sample 7.
    task automatic send_frame(input int gap_at, input int gap_len, input bit hold,
                              input bit push, output int edge0);
        int w;
        exp_t e;
        for (int n = 0; n < 8; n++) begin
            in_valid = 1'b1;
            xr = DW'(f_re[n]);
            xi = DW'(f_im[n]);
            w = 0;
            while (!in_ready && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (!in_ready) chk("in_ready_wait_timeout", int'(in_ready), 1);
            @(posedge clk); #1;
            if (n == gap_at) begin
                in_valid = 1'b0;
                repeat (gap_len) begin
                    @(posedge clk); #1;
                end
            end
        end
        edge0 = cyc;
        if (push) begin
            for (int k = 0; k < 8; k++) begin
                e.cyc = edge0 + 12 + k;
                e.idx = k;
                e.re  = e_re[k];
                e.im  = e_im[k];
                sb.push_back(e);
            end
        end
        if (hold) begin
            xr = 12'sd1000;
            xi = -12'sd777;
            for (int c = 1; c <= 20; c++) begin
                chk($sformatf("in_ready_cycle%0d", c), int'(in_ready), 0);
                @(posedge clk); #1;
            end
            chk("in_ready_cycle21", int'(in_ready), 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int w = 0;
        while ((sb.size() != 0 || out_valid) && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk({name, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        xr = '0;
        xi = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_yr", int'(yr), 0);
        chk("rst_yi", int'(yi), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // impulse
        f_re = '{800, 0, 0, 0, 0, 0, 0, 0};
        f_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        e_re = '{100, 100, 100, 100, 100, 100, 100, 100};
        e_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(-1, 0, 1'b0, 1'b1, e0);
        chk("calc_busy", int'(busy), 1);
        drain("impulse");
        chk("idle_busy", int'(busy), 0);

        // DC
        f_re = '{400, 400, 400, 400, 400, 400, 400, 400};
        e_re = '{400, 0, 0, 0, 0, 0, 0, 0};
        send_frame(-1, 0, 1'b0, 1'b1, e0);
        drain("dc");

        // alternating sign
        f_re = '{256, -256, 256, -256, 256, -256, 256, -256};
        e_re = '{0, 0, 0, 0, 256, 0, 0, 0};
        send_frame(-1, 0, 1'b0, 1'b1, e0);
        drain("alternating");

        // gapped impulse
        f_re = '{800, 0, 0, 0, 0, 0, 0, 0};
        e_re = '{100, 100, 100, 100, 100, 100, 100, 100};
        send_frame(2, 3, 1'b0, 1'b1, e0);
        drain("gapped");

        // in_valid held high through CALC/OUT with junk data
        f_re = '{256, -256, 256, -256, 256, -256, 256, -256};
        e_re = '{0, 0, 0, 0, 256, 0, 0, 0};
        send_frame(-1, 0, 1'b1, 1'b1, e0);
        drain("ignored_input");

        // impulse at n=1 exercises every twiddle
        f_re = '{0, 800, 0, 0, 0, 0, 0, 0};
`ifdef FFT8_ROUND_EN
        e_re = '{100, 71, 0, -70, -100, -70, 0, 71};
        e_im = '{0, -70, -100, -70, 0, 71, 100, 71};
`else
        e_re = '{100, 70, 0, -71, -100, -71, 0, 71};
        e_im = '{0, -71, -100, -71, 0, 71, 100, 71};
`endif
        send_frame(-1, 0, 1'b0, 1'b1, e0);
        drain("twiddle");
        chk("yr_hold_idle", int'(yr), e_re[7]);
        chk("yi_hold_idle", int'(yi), e_im[7]);

        // reset in cycle 6 of CALC aborts the frame
        f_re = '{400, 400, 400, 400, 400, 400, 400, 400};
        e_re = '{400, 0, 0, 0, 0, 0, 0, 0};
        e_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(-1, 0, 1'b0, 1'b0, e0);
        repeat (5) @(posedge clk);
        #1;
        chk("midcalc_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_yr", int'(yr), 0);
        chk("abort_yi", int'(yi), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("release_in_ready", int'(in_ready), 1);
        send_frame(-1, 0, 1'b0, 1'b1, e0);
        drain("after_reset");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=%0t required=<100000", $time);
        $fatal(1, "watchdog");
    end

endmodule
